// File: rtl/fifo_control_pkg.sv
// FIFO control shared parameters and types.
// Also used by the memory stage so geometry stays in one place.
package fifo_control_pkg;

  localparam int MEM_SIZE_C = 8;
  localparam int PTR_C      = 3;
  localparam int AF_TH_C    = 6;
  localparam int AE_TH_C    = 2;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } flags_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } errs_t;

endpackage

// File: rtl/fifo_control_if.sv
// Request/strobe/status bundle between FIFO control,
// its requesters and the memory stage.
interface fifo_control_if
  import fifo_control_pkg::*;
#(
  parameter int PTR = PTR_C
);

  logic           push_req;
  logic           pop_req;
  logic           push;
  logic           pop;
  logic [PTR-1:0] wr_ptr;
  logic [PTR-1:0] rd_ptr;
  logic [PTR:0]   count;
  logic           full;
  logic           empty;
  logic           almost_full;
  logic           almost_empty;
  logic           overflow_err;
  logic           underflow_err;

  modport master (
    output push_req,
    output pop_req,
    input  push,
    input  pop,
    input  wr_ptr,
    input  rd_ptr,
    input  count,
    input  full,
    input  empty,
    input  almost_full,
    input  almost_empty,
    input  overflow_err,
    input  underflow_err
  );

  modport slave (
    input  push_req,
    input  pop_req,
    output push,
    output pop,
    output wr_ptr,
    output rd_ptr,
    output count,
    output full,
    output empty,
    output almost_full,
    output almost_empty,
    output overflow_err,
    output underflow_err
  );

endinterface

// File: rtl/fifo_control_ptr_counter.sv
// Wrapping address pointer: 0..MEM_SIZE-1, advances when enabled.
// Works for non-power-of-two depths.
module ptr_counter
  import fifo_control_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_C,
  parameter int PTR      = PTR_C
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en_i,
  output logic [PTR-1:0] ptr_o
);

  localparam logic [PTR-1:0] LAST = PTR'(MEM_SIZE - 1);
  localparam logic [PTR-1:0] ONE  = PTR'(1);

  logic [PTR-1:0] ptr_q;
  logic [PTR-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      if (ptr_q == LAST) ptr_d = '0;
      else               ptr_d = ptr_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_control.sv
// FIFO control: qualifies requests, tracks pointers/occupancy,
// decodes flags and keeps sticky overflow/underflow errors.
module fifo_control
  import fifo_control_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_C,
  parameter int PTR      = PTR_C,
  parameter int AF_TH    = AF_TH_C,
  parameter int AE_TH    = AE_TH_C
) (
  input  logic          clk,
  input  logic          reset,
  fifo_control_if.slave bus
);

  localparam logic [PTR:0] FULL_C = (PTR+1)'(MEM_SIZE);
  localparam logic [PTR:0] AF_C   = (PTR+1)'(AF_TH);
  localparam logic [PTR:0] AE_C   = (PTR+1)'(AE_TH);
  localparam logic [PTR:0] ONE    = (PTR+1)'(1);

  logic [PTR:0] count_q;
  logic [PTR:0] count_d;
  errs_t        errs_q;
  errs_t        errs_d;
  flags_t       flags;
  logic         push;
  logic         pop;

  always_comb begin
    flags.full         = (count_q == FULL_C);
    flags.empty        = (count_q == '0);
    flags.almost_full  = (count_q >= AF_C);
    flags.almost_empty = (count_q <= AE_C);
  end

  // Strobes are gated by reset so nothing reaches memory during it
  assign push = bus.push_req & ~flags.full  & ~reset;
  assign pop  = bus.pop_req  & ~flags.empty & ~reset;

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      (push & ~pop): count_d = count_q + ONE;
      (pop & ~push): count_d = count_q - ONE;
      default:       count_d = count_q;
    endcase
  end

  // A simultaneous opposite request masks the error: one side is served
  always_comb begin
    errs_d = errs_q;
    if (bus.push_req & flags.full & ~bus.pop_req)
      errs_d.overflow = 1'b1;
    if (bus.pop_req & flags.empty & ~bus.push_req)
      errs_d.underflow = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      errs_q  <= '0;
    end else begin
      count_q <= count_d;
      errs_q  <= errs_d;
    end
  end

  ptr_counter #(
    .MEM_SIZE (MEM_SIZE),
    .PTR      (PTR)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en_i  (push),
    .ptr_o (bus.wr_ptr)
  );

  ptr_counter #(
    .MEM_SIZE (MEM_SIZE),
    .PTR      (PTR)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en_i  (pop),
    .ptr_o (bus.rd_ptr)
  );

  assign bus.push          = push;
  assign bus.pop           = pop;
  assign bus.count         = count_q;
  assign bus.full          = flags.full;
  assign bus.empty         = flags.empty;
  assign bus.almost_full   = flags.almost_full;
  assign bus.almost_empty  = flags.almost_empty;
  assign bus.overflow_err  = errs_q.overflow;
  assign bus.underflow_err = errs_q.underflow;

endmodule

// File: tb/tb_fifo_control.sv
// Directed self-checking bench for fifo_control
// (MEM_SIZE=8, PTR=3, AF_TH=6, AE_TH=2).
module tb_fifo_control;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  fifo_control_if #(.PTR(3)) bus ();

  fifo_control #(
    .MEM_SIZE (8),
    .PTR      (3),
    .AF_TH    (6),
    .AE_TH    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.push_req = 1'b0;
    bus.pop_req  = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.push_req = 1'b1;
    bus.pop_req  = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.push !== 1'b0 || bus.pop !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_strobes push=%b pop=%b exp 0 0", bus.push, bus.pop);
    end
    cycle();
    reset = 1'b0;
    bus.push_req = 1'b0;
    bus.pop_req  = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.count !== 4'd0 || bus.wr_ptr !== 3'd0 || bus.rd_ptr !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state count=%0d wr=%0d rd=%0d exp 0 0 0",
               bus.count, bus.wr_ptr, bus.rd_ptr);
    end
    tests_run++;
    if ({bus.empty, bus.almost_empty, bus.full, bus.almost_full} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_flags e/ae/f/af=%b%b%b%b exp 1100",
               bus.empty, bus.almost_empty, bus.full, bus.almost_full);
    end
    tests_run++;
    if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_errs ovf=%b unf=%b exp 0 0",
               bus.overflow_err, bus.underflow_err);
    end
  endtask

  task automatic test_fill();
    bus.push_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      tests_run++;
      if (bus.count !== 4'(i) || bus.push !== 1'b1 || bus.wr_ptr !== 3'(i)) begin
        tests_failed++;
        $display("FAIL fill_step%0d count=%0d push=%b wr=%0d exp %0d 1 %0d",
                 i, bus.count, bus.push, bus.wr_ptr, i, i);
      end
      tests_run++;
      if (bus.almost_full !== (i >= 6) || bus.almost_empty !== (i <= 2)
          || bus.full !== 1'b0 || bus.empty !== (i == 0)) begin
        tests_failed++;
        $display("FAIL fill_flags%0d af=%b ae=%b f=%b e=%b", i,
                 bus.almost_full, bus.almost_empty, bus.full, bus.empty);
      end
      cycle();
    end
    bus.push_req = 1'b0;
    #1;
    tests_run++;
    if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.wr_ptr !== 3'd0
        || bus.almost_full !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_full count=%0d full=%b wr=%0d af=%b exp 8 1 0 1",
               bus.count, bus.full, bus.wr_ptr, bus.almost_full);
    end
  endtask

  task automatic test_overflow();
    bus.push_req = 1'b1;
    bus.pop_req  = 1'b0;
    #1;
    tests_run++;
    if (bus.push !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_push push=%b exp 0", bus.push);
    end
    cycle();
    bus.push_req = 1'b0;
    #1;
    tests_run++;
    if (bus.count !== 4'd8 || bus.wr_ptr !== 3'd0 || bus.rd_ptr !== 3'd0
        || bus.overflow_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_state count=%0d wr=%0d rd=%0d ovf=%b exp 8 0 0 1",
               bus.count, bus.wr_ptr, bus.rd_ptr, bus.overflow_err);
    end
    bus.pop_req = 1'b1;
    cycle();
    cycle();
    bus.pop_req = 1'b0;
    #1;
    tests_run++;
    if (bus.overflow_err !== 1'b1 || bus.count !== 4'd6) begin
      tests_failed++;
      $display("FAIL ovf_sticky ovf=%b count=%0d exp 1 6",
               bus.overflow_err, bus.count);
    end
    do_reset();
    #1;
    tests_run++;
    if (bus.overflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clear ovf=%b exp 0", bus.overflow_err);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    bus.pop_req = 1'b1;
    #1;
    tests_run++;
    if (bus.pop !== 1'b0) begin
      tests_failed++;
      $display("FAIL unf_pop pop=%b exp 0", bus.pop);
    end
    cycle();
    bus.pop_req = 1'b0;
    cycle();
    tests_run++;
    if (bus.underflow_err !== 1'b1 || bus.rd_ptr !== 3'd0 || bus.count !== 4'd0) begin
      tests_failed++;
      $display("FAIL unf_state unf=%b rd=%0d count=%0d exp 1 0 0",
               bus.underflow_err, bus.rd_ptr, bus.count);
    end
    do_reset();
    #1;
    tests_run++;
    if (bus.underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL unf_clear unf=%b exp 0", bus.underflow_err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.push_req = 1'b1;
    repeat (4) cycle();
    bus.pop_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      tests_run++;
      if (bus.push !== 1'b1 || bus.pop !== 1'b1 || bus.count !== 4'd4
          || bus.wr_ptr !== 3'((4 + k) % 8) || bus.rd_ptr !== 3'(k % 8)) begin
        tests_failed++;
        $display("FAIL b2b_%0d push=%b pop=%b count=%0d wr=%0d rd=%0d exp 1 1 4 %0d %0d",
                 k, bus.push, bus.pop, bus.count, bus.wr_ptr, bus.rd_ptr,
                 (4 + k) % 8, k % 8);
      end
      cycle();
    end
    bus.push_req = 1'b0;
    bus.pop_req  = 1'b0;
    #1;
    tests_run++;
    if (bus.count !== 4'd4 || bus.wr_ptr !== 3'd0 || bus.rd_ptr !== 3'd4) begin
      tests_failed++;
      $display("FAIL b2b_end count=%0d wr=%0d rd=%0d exp 4 0 4",
               bus.count, bus.wr_ptr, bus.rd_ptr);
    end
  endtask

  task automatic test_both_edges();
    do_reset();
    bus.push_req = 1'b1;
    bus.pop_req  = 1'b1;
    #1;
    tests_run++;
    if (bus.push !== 1'b1 || bus.pop !== 1'b0) begin
      tests_failed++;
      $display("FAIL both_empty_strobe push=%b pop=%b exp 1 0", bus.push, bus.pop);
    end
    cycle();
    bus.pop_req = 1'b0;
    #1;
    tests_run++;
    if (bus.count !== 4'd1 || bus.underflow_err !== 1'b0 || bus.wr_ptr !== 3'd1) begin
      tests_failed++;
      $display("FAIL both_empty count=%0d unf=%b wr=%0d exp 1 0 1",
               bus.count, bus.underflow_err, bus.wr_ptr);
    end
    repeat (7) cycle();
    bus.pop_req = 1'b1;
    #1;
    tests_run++;
    if (bus.push !== 1'b0 || bus.pop !== 1'b1 || bus.count !== 4'd8) begin
      tests_failed++;
      $display("FAIL both_full_strobe push=%b pop=%b count=%0d exp 0 1 8",
               bus.push, bus.pop, bus.count);
    end
    cycle();
    bus.push_req = 1'b0;
    bus.pop_req  = 1'b0;
    #1;
    tests_run++;
    if (bus.count !== 4'd7 || bus.overflow_err !== 1'b0 || bus.full !== 1'b0
        || bus.rd_ptr !== 3'd1) begin
      tests_failed++;
      $display("FAIL both_full count=%0d ovf=%b full=%b rd=%0d exp 7 0 0 1",
               bus.count, bus.overflow_err, bus.full, bus.rd_ptr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.push_req = 1'b1;
    repeat (5) cycle();
    bus.push_req = 1'b0;
    #1;
    tests_run++;
    if (bus.count !== 4'd5) begin
      tests_failed++;
      $display("FAIL mid_pre count=%0d exp 5", bus.count);
    end
    reset = 1'b1;
    bus.push_req = 1'b1;
    bus.pop_req  = 1'b1;
    #1;
    tests_run++;
    if (bus.push !== 1'b0 || bus.pop !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_strobes push=%b pop=%b exp 0 0", bus.push, bus.pop);
    end
    cycle();
    reset = 1'b0;
    bus.push_req = 1'b0;
    bus.pop_req  = 1'b0;
    #1;
    tests_run++;
    if (bus.count !== 4'd0 || bus.wr_ptr !== 3'd0 || bus.rd_ptr !== 3'd0
        || bus.empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_after count=%0d wr=%0d rd=%0d empty=%b exp 0 0 0 1",
               bus.count, bus.wr_ptr, bus.rd_ptr, bus.empty);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.push_req = 1'b0;
    bus.pop_req  = 1'b0;
    cycle();
    test_reset();
    cycle();
    test_fill();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_both_edges();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
